// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit opcode encodings, also used by the top-level ALU decoder.
package alu_pkg;

    localparam int LOP_W = 3;

    localparam logic [LOP_W-1:0] LOP_AND   = 3'b000;
    localparam logic [LOP_W-1:0] LOP_XOR   = 3'b001;
    localparam logic [LOP_W-1:0] LOP_OR    = 3'b010;
    localparam logic [LOP_W-1:0] LOP_NOR   = 3'b011;
    localparam logic [LOP_W-1:0] LOP_XNOR  = 3'b100;
    localparam logic [LOP_W-1:0] LOP_ANDN  = 3'b101;
    localparam logic [LOP_W-1:0] LOP_PASSA = 3'b110;
    localparam logic [LOP_W-1:0] LOP_PASSB = 3'b111;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Valid/ready operand and result bundle of the pipelined logic unit.
interface logic_unit_pipe_if #(parameter int WIDTH = 32);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [LOP_W-1:0] op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             parity;
    logic             msb;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, c, zero, parity, msb, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, c, zero, parity, msb, busy
    );

endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise operation plus result flags; no state.
module logic_op_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [LOP_W-1:0] op,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             parity,
    output logic             msb
);

    always_comb begin
        c = '0;
        case (op)
            LOP_AND:   c = a & b;
            LOP_XOR:   c = a ^ b;
            LOP_OR:    c = a | b;
            LOP_NOR:   c = ~(a | b);
            LOP_XNOR:  c = ~(a ^ b);
            LOP_ANDN:  c = a & ~b;
            LOP_PASSA: c = a;
            LOP_PASSB: c = b;
            default:   c = '0;
        endcase
    end

    assign zero   = (c == '0);
    assign parity = ^c;
    assign msb    = c[WIDTH-1];

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit: S1 captures operands, S2 registers result and flags.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    logic_unit_pipe_if.slave bus
);

    logic             adv1;
    logic             adv2;

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [LOP_W-1:0] op_p1;

    logic [WIDTH-1:0] c_nxt;
    logic             zero_nxt;
    logic             parity_nxt;
    logic             msb_nxt;

    logic             vld_p2;
    logic [WIDTH-1:0] c_p2;
    logic             zero_p2;
    logic             parity_p2;
    logic             msb_p2;

    // A stage may load when it is empty or its contents move on this edge.
    assign adv2 = !vld_p2 | bus.out_ready;
    assign adv1 = !vld_p1 | adv2;

    // ---- S1: operand capture ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            a_p1  <= bus.a;
            b_p1  <= bus.b;
            op_p1 <= bus.op;
        end
    end

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .a      (a_p1),
        .b      (b_p1),
        .op     (op_p1),
        .c      (c_nxt),
        .zero   (zero_nxt),
        .parity (parity_nxt),
        .msb    (msb_nxt)
    );

    // ---- S2: result and flags; data reset too so outputs read a clean zero result ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            c_p2      <= '0;
            zero_p2   <= 1'b1;
            parity_p2 <= 1'b0;
            msb_p2    <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                c_p2      <= c_nxt;
                zero_p2   <= zero_nxt;
                parity_p2 <= parity_nxt;
                msb_p2    <= msb_nxt;
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = vld_p2;
    assign bus.c         = c_p2;
    assign bus.zero      = zero_p2;
    assign bus.parity    = parity_p2;
    assign bus.msb       = msb_p2;
    assign bus.busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: vector table, scoreboard, back-pressure, reset and 8-bit build.
module tb_logic_unit_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] c;
        logic        z;
        logic        p;
        logic        m;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [LOP_W-1:0] op;
        logic [31:0]      c;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b0;
    exp_t exp_cur;
    exp_t sb[$];
    vec_t stim_q[$];

    logic_unit_pipe_if #(.WIDTH(32)) bus ();
    logic_unit_pipe_if #(.WIDTH(8))  bus8 ();

    logic_unit_pipe #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic_unit_pipe #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mkexp(input logic [31:0] c);
        exp_t e;
        e.c = c;
        e.z = (c == 32'h0);
        e.p = ^c;
        e.m = c[31];
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a ^ b;
            3'd2: return a | b;
            3'd3: return ~(a | b);
            3'd4: return ~(a ^ b);
            3'd5: return a & ~b;
            3'd6: return a;
            default: return b;
        endcase
    endfunction

    // Scoreboard: capture accepted inputs, compare delivered outputs.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("c", 64'(bus.c), 64'(e.c));
                    check("flags", {61'd0, bus.zero, bus.parity, bus.msb}, {61'd0, e.z, e.p, e.m});
                    if (chk_lat) check("latency", 64'(cyc_cnt - e.cyc), 64'd2);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = exp_cur;
                e.cyc = cyc_cnt;
                sb.push_back(e);
            end
        end
    end

    task automatic stream(input int stall, input bit chk_bp, input bit chk_full);
        int idx = 0;
        int cyc = 0;
        int n = stim_q.size();
        int out0 = n_out;
        logic [31:0] c_hold = '0;
        while ((idx < n || sb.size() != 0 || bus.busy) && cyc < 200) begin
            @(posedge clk); #1;
            bus.out_ready = (cyc >= stall);
            if (idx < n) begin
                bus.in_valid = 1'b1;
                bus.a  = stim_q[idx].a;
                bus.b  = stim_q[idx].b;
                bus.op = stim_q[idx].op;
                exp_cur = mkexp(stim_q[idx].c);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (chk_bp && cyc == 2) begin
                check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                check("bp_beats_taken", 64'(idx), 64'd2);
                c_hold = bus.c;
            end
            if (chk_bp && cyc == 3) check("bp_c_stable", 64'(bus.c), 64'(c_hold));
            if (chk_full && bus.in_valid) check("full_in_ready", 64'(bus.in_ready), 64'd1);
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        check("stream_timeout", 64'(cyc < 200), 64'd1);
        check("stream_count", 64'(n_out - out0), 64'(n));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        stim_q.delete();
    endtask

    initial begin
        vec_t vt[8];
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        bit found;

        vt[0] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_AND,   32'hF000_000F};
        vt[1] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_XOR,   32'h0FF0_0FF0};
        vt[2] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_OR,    32'hFFF0_0FFF};
        vt[3] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_NOR,   32'h000F_F000};
        vt[4] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_XNOR,  32'hF00F_F00F};
        vt[5] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_ANDN,  32'h00F0_00F0};
        vt[6] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_PASSA, 32'hF0F0_00FF};
        vt[7] = '{32'hF0F0_00FF, 32'hFF00_0F0F, LOP_PASSB, 32'hFF00_0F0F};

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.out_ready = 1'b1;
        exp_cur = mkexp(32'h0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_c", 64'(bus.c), 64'd0);
        check("rst_flags", {61'd0, bus.zero, bus.parity, bus.msb}, 64'b100);

        // Ops sweep, back to back with latency checked.
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) stim_q.push_back(vt[i]);
        stream(0, 1'b0, 1'b1);

        // Flag corners.
        stim_q.push_back('{32'h1234_5678, 32'h1234_5678, LOP_XOR, 32'h0});
        stim_q.push_back('{32'h8000_0001, 32'h0, LOP_OR, 32'h8000_0001});
        stream(0, 1'b0, 1'b0);

        // Full throughput, 16 random beats.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
            stim_q.push_back('{ra, rb, rop, model(ra, rb, rop)});
        end
        stream(0, 1'b0, 1'b1);
        chk_lat = 1'b0;

        // Back-pressure: out_ready low for three cycles.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom; rop = 3'(i + 1);
            stim_q.push_back('{ra, rb, rop, model(ra, rb, rop)});
        end
        stream(3, 1'b1, 1'b0);

        // Reset with both stages full.
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h0; bus.op = LOP_PASSA;
        exp_cur = mkexp(32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_busy", 64'(bus.busy), 64'd1);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_c", 64'(bus.c), 64'd0);
        check("mid_rst_zero", 64'(bus.zero), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_out", 64'(bus.out_valid), 64'd0);
        end

        // 8-bit build.
        @(posedge clk); #1;
        bus8.in_valid = 1'b1; bus8.a = 8'h0F; bus8.b = 8'hF0; bus8.op = LOP_NOR;
        @(posedge clk); #1 bus8.in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus8.out_valid) begin
                found = 1'b1;
                check("w8_c", 64'(bus8.c), 64'h00);
                check("w8_zero", 64'(bus8.zero), 64'd1);
            end
        end
        check("w8_out_seen", 64'(found), 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
